// File: rtl/rbot_pkg.sv
// ============================================================================
// Module   : rbot_pkg
// Purpose  : Shared colour codes, cube geometry and scan-sequencer states.
// Revision : 1.0
// ============================================================================
`default_nettype none

package rbot_pkg;

  localparam int NUM_FACELETS  = 54;
  localparam int FACELET_IDX_W = 6;

  localparam logic [2:0] COLOR_W   = 3'd0;
  localparam logic [2:0] COLOR_O   = 3'd1;
  localparam logic [2:0] COLOR_G   = 3'd2;
  localparam logic [2:0] COLOR_R   = 3'd3;
  localparam logic [2:0] COLOR_B   = 3'd4;
  localparam logic [2:0] COLOR_Y   = 3'd5;
  localparam logic [2:0] COLOR_MAX = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_MOVE     = 3'd1,
    S_SETTLE   = 3'd2,
    S_SAMPLE   = 3'd3,
    S_CLASSIFY = 3'd4,
    S_WRITE    = 3'd5,
    S_DONE     = 3'd6
  } scan_state_t;

endpackage

`default_nettype wire

// File: rtl/rgb_averager.sv
// ============================================================================
// Module   : rgb_averager
// Purpose  : Accumulates 2^SAMPLES_LOG2 RGB samples and latches the average.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rgb_averager #(
  parameter int SAMPLES_LOG2 = 2
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       clear,
  input  logic       enable,
  input  logic [7:0] red_in,
  input  logic [7:0] green_in,
  input  logic [7:0] blue_in,
  output logic [7:0] avg_red,
  output logic [7:0] avg_green,
  output logic [7:0] avg_blue,
  output logic       full
);

  localparam int ACC_W = 8 + SAMPLES_LOG2;

  logic [ACC_W-1:0]        acc_red;
  logic [ACC_W-1:0]        acc_green;
  logic [ACC_W-1:0]        acc_blue;
  logic [SAMPLES_LOG2-1:0] count;

  logic [ACC_W-1:0] sum_red;
  logic [ACC_W-1:0] sum_green;
  logic [ACC_W-1:0] sum_blue;

  assign sum_red   = acc_red   + ACC_W'(red_in);
  assign sum_green = acc_green + ACC_W'(green_in);
  assign sum_blue  = acc_blue  + ACC_W'(blue_in);

  // High while the sample completing the set is being accumulated.
  assign full = enable && (count == '1);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc_red   <= '0;
      acc_green <= '0;
      acc_blue  <= '0;
      count     <= '0;
      avg_red   <= '0;
      avg_green <= '0;
      avg_blue  <= '0;
    end else if (clear) begin
      acc_red   <= '0;
      acc_green <= '0;
      acc_blue  <= '0;
      count     <= '0;
    end else if (enable) begin
      acc_red   <= sum_red;
      acc_green <= sum_green;
      acc_blue  <= sum_blue;
      count     <= count + SAMPLES_LOG2'(1);
      if (full) begin
        avg_red   <= sum_red[ACC_W-1:SAMPLES_LOG2];
        avg_green <= sum_green[ACC_W-1:SAMPLES_LOG2];
        avg_blue  <= sum_blue[ACC_W-1:SAMPLES_LOG2];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/color_scan_sequencer.sv
// ============================================================================
// Module   : color_scan_sequencer
// Purpose  : Steps the sensor arm over every facelet, averages RGB samples,
//            and stores the classified colour code per facelet.
// Revision : 1.0
// ============================================================================
`default_nettype none

module color_scan_sequencer #(
  parameter int NUM_FACELETS  = rbot_pkg::NUM_FACELETS,
  parameter int SAMPLES_LOG2  = 2,
  parameter int SETTLE_CYCLES = 100000,
  parameter int CLASSIFY_LAT  = 1
) (
  input  logic                              clock,
  input  logic                              reset_n,
  input  logic                              start,
  input  logic                              abort,
  output logic                              move_req,
  output logic [rbot_pkg::FACELET_IDX_W-1:0] move_index,
  input  logic                              move_ack,
  input  logic                              sample_valid,
  input  logic [7:0]                        red_in,
  input  logic [7:0]                        green_in,
  input  logic [7:0]                        blue_in,
  output logic [7:0]                        avg_red,
  output logic [7:0]                        avg_green,
  output logic [7:0]                        avg_blue,
  input  logic [2:0]                        color_in,
  output logic                              wr_en,
  output logic [rbot_pkg::FACELET_IDX_W-1:0] wr_addr,
  output logic [2:0]                        wr_color,
  output logic                              busy,
  output logic                              done,
  output logic                              bad_color
);

  import rbot_pkg::*;

  localparam int IDX_W   = FACELET_IDX_W;
  localparam int CNT_MAX = (SETTLE_CYCLES > CLASSIFY_LAT) ? SETTLE_CYCLES : CLASSIFY_LAT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [IDX_W-1:0] LAST_IDX      = IDX_W'(NUM_FACELETS - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST   = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CLASSIFY_LAST = CNT_W'(CLASSIFY_LAT - 1);

  scan_state_t      state;
  logic [IDX_W-1:0] index;
  logic [CNT_W-1:0] wait_cnt;

  logic avg_clear;
  logic avg_enable;
  logic avg_full;

  assign move_index = index;

  // Abort wins over a coincident sample; accumulators restart on every
  // new scan and after each facelet write.
  assign avg_enable = (state == S_SAMPLE) && sample_valid && !abort;
  assign avg_clear  = abort || (state == S_WRITE) || ((state == S_IDLE) && start);

  rgb_averager #(
    .SAMPLES_LOG2 (SAMPLES_LOG2)
  ) u_averager (
    .clock     (clock),
    .reset_n   (reset_n),
    .clear     (avg_clear),
    .enable    (avg_enable),
    .red_in    (red_in),
    .green_in  (green_in),
    .blue_in   (blue_in),
    .avg_red   (avg_red),
    .avg_green (avg_green),
    .avg_blue  (avg_blue),
    .full      (avg_full)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      index     <= '0;
      wait_cnt  <= '0;
      move_req  <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_color  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      bad_color <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      done  <= 1'b0;
      if (abort) begin
        state    <= S_IDLE;
        move_req <= 1'b0;
        busy     <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              state     <= S_MOVE;
              index     <= '0;
              wait_cnt  <= '0;
              move_req  <= 1'b1;
              busy      <= 1'b1;
              bad_color <= 1'b0;
            end
          end
          S_MOVE: begin
            if (move_ack) begin
              state    <= S_SETTLE;
              move_req <= 1'b0;
              wait_cnt <= '0;
            end
          end
          S_SETTLE: begin
            if (wait_cnt == SETTLE_LAST) begin
              state    <= S_SAMPLE;
              wait_cnt <= '0;
            end else begin
              wait_cnt <= wait_cnt + CNT_W'(1);
            end
          end
          S_SAMPLE: begin
            if (avg_full) begin
              state    <= S_CLASSIFY;
              wait_cnt <= '0;
            end
          end
          S_CLASSIFY: begin
            // color_in is captured on the edge closing the last CLASSIFY cycle.
            if (wait_cnt == CLASSIFY_LAST) begin
              state    <= S_WRITE;
              wr_en    <= 1'b1;
              wr_addr  <= index;
              wr_color <= color_in;
              if (color_in > COLOR_MAX) begin
                bad_color <= 1'b1;
              end
            end else begin
              wait_cnt <= wait_cnt + CNT_W'(1);
            end
          end
          S_WRITE: begin
            if (index == LAST_IDX) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state    <= S_MOVE;
              index    <= index + IDX_W'(1);
              move_req <= 1'b1;
            end
          end
          S_DONE: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state    <= S_IDLE;
            move_req <= 1'b0;
            busy     <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire
